seq_block_borrow_lookahead_sub: RTL and testbench
=================================================

SEQ_BLOCK_BORROW_LOOKAHEAD_SUB -- requirements
Module: seq_block_borrow_lookahead_sub

Interface
REQ-001 SHALL have parameter N, default 32: datapath width in bits.
REQ-002 SHALL have parameter W, default 8: block width in bits, processed one block per clock.
REQ-003 SHALL have a port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have a port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have a port in_valid, input, 1 bit: the operands are valid.
REQ-006 SHALL have a port in_ready, output, 1 bit: the block can accept operands.
REQ-007 SHALL have a port a, input, N bits: minuend.
REQ-008 SHALL have a port b, input, N bits: subtrahend.
REQ-009 SHALL have a port bi, input, 1 bit: borrow in.
REQ-010 SHALL have a port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have a port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have a port d, output, N bits: difference, a - b - bi modulo 2^N.
REQ-013 SHALL have a port bo, output, 1 bit: borrow out; 1 iff a < b + bi, unsigned.
REQ-014 SHALL have a port ov, output, 1 bit: signed two's-complement overflow.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE; the reset state is IDLE.
REQ-016 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 SHALL, in IDLE on in_valid & in_ready, register a, b and bi, clear the block counter, and go to RUN.
REQ-018 SHALL, in RUN, each cycle compute block k (bits k*W+W-1 : k*W) from the registered operands and the running borrow (bi for k=0), write that slice of d, update the borrow, and increment k.
REQ-019 SHALL compute the per-block borrow by lookahead: bit generate = ~a & b, bit propagate = ~(a ^ b); there SHALL be no ripple across more than W bits per cycle.
REQ-020 SHALL, when k = N/W-1 completes, latch bo = final borrow and ov = (a[N-1] != b[N-1]) & (d[N-1] != a[N-1]), and go to DONE.
REQ-021 SHALL give a latency of N/W cycles: accept at edge T, out_valid high after edge T+N/W.
REQ-022 SHALL, in DONE, hold d, bo and ov stable while out_ready = 0.
REQ-023 SHALL, in DONE on out_ready = 1, go to IDLE; a new operand is accepted no earlier than the following cycle.
REQ-024 SHALL ignore in_valid outside IDLE; in-flight operands are never overwritten.
REQ-025 SHALL keep d, bo and ov at their last values in IDLE and RUN, except for the slice being written in RUN.
REQ-026 SHALL fail elaboration when N % W != 0 or W < 1; W = N gives a latency of 1.

Reset
REQ-027 SHALL, on rst_n = 0 at a clock edge, set state = IDLE, d = 0, bo = 0, ov = 0, out_valid = 0, the counter to 0 and the borrow to 0, regardless of state.
REQ-028 SHALL, on reset mid-RUN or mid-DONE, discard the operation with no partial result visible; in_ready = 1 in the first cycle after rst_n returns high.

Structure
REQ-029 SHALL place the FSM state enum and the N % W check helper in the shared package fixed_point_arith_pkg.
REQ-030 SHALL use one combinational sub-module, borrow_lookahead_sub_block (W-bit a, b, bin -> d, bout), instantiated once and reused each cycle.
REQ-031 SHALL use no latches and no asynchronous logic; the counter width SHALL be $clog2(N/W), minimum 1.

Verification (N=32, W=8)
REQ-032 SHALL test a=0x00000005, b=0x00000003, bi=0 -> d=0x00000002, bo=0, ov=0, out_valid exactly 4 cycles after accept.
REQ-033 SHALL test a=0x00000000, b=0x00000001, bi=0 -> d=0xFFFFFFFF, bo=1, ov=0.
REQ-034 SHALL test a=0x80000000, b=0x00000001, bi=0 -> d=0x7FFFFFFF, bo=0, ov=1.
REQ-035 SHALL test a=0x00010000, b=0x00000000, bi=1 (borrow crossing two block boundaries) -> d=0x0000FFFF, bo=0.
REQ-036 SHALL test out_ready held at 0 for 3 cycles in DONE -> d, bo and ov stable, in_ready=0, second in_valid ignored; after the out_ready pulse, IDLE with in_ready=1.
REQ-037 SHALL test rst_n=0 for one cycle at RUN k=2 -> d=0, bo=0, ov=0, out_valid=0, in_ready=1 in the next cycle, and no stale out_valid afterwards.

Source files
------------

// File: rtl/fixed_point_arith_pkg.sv
// ---------------------------------------------------------------------------
// fixed_point_arith_pkg
// Shared definitions for the block-serial arithmetic units.
//   sub_state_e     : control states of the block-serial subtractor
//   block_split_ok  : true when an N-bit datapath splits evenly into W-bit
//                     blocks with W >= 1 (used as an elaboration guard)
// ---------------------------------------------------------------------------
package fixed_point_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sub_state_e;

    function automatic bit block_split_ok(input int n, input int w);
        if (w < 1) begin
            return 1'b0;
        end
        return (n % w) == 0;
    endfunction

endpackage : fixed_point_arith_pkg

// File: rtl/borrow_lookahead_sub_block.sv
// ---------------------------------------------------------------------------
// borrow_lookahead_sub_block
// Purely combinational W-bit subtractor slice: d = a - b - bin, with the
// borrow into every bit position formed by lookahead rather than rippled.
// Ports:
//   a    [W-1:0] in  : minuend slice
//   b    [W-1:0] in  : subtrahend slice
//   bin          in  : borrow into bit 0
//   d    [W-1:0] out : difference slice
//   bout         out : borrow out of bit W-1
// ---------------------------------------------------------------------------
module borrow_lookahead_sub_block #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    // A bit generates a borrow when it subtracts 1 from 0, and passes an
    // incoming borrow through when both operand bits are equal.
    logic [W-1:0] gen_bits;
    logic [W-1:0] prop_bits;
    logic [W:0]   borrow;

    assign gen_bits  = ~a & b;
    assign prop_bits = ~(a ^ b);
    assign borrow[0] = bin;

    // Each borrow[gi+1] is the flat sum of products
    //   g[gi] | p[gi]g[gi-1] | ... | p[gi..1]g[0] | p[gi..0]bin
    // so no borrow depends on another computed borrow.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_borrow
            always_comb begin
                logic acc;
                logic prod;
                acc = bin & (&prop_bits[gi:0]);
                for (int j = 0; j <= gi; j++) begin
                    prod = gen_bits[j];
                    for (int k = j + 1; k <= gi; k++) begin
                        prod = prod & prop_bits[k];
                    end
                    acc = acc | prod;
                end
                borrow[gi+1] = acc;
            end

            assign d[gi] = a[gi] ^ b[gi] ^ borrow[gi];
        end
    endgenerate

    assign bout = borrow[W];

endmodule : borrow_lookahead_sub_block

// File: rtl/seq_block_borrow_lookahead_sub.sv
// ---------------------------------------------------------------------------
// seq_block_borrow_lookahead_sub
// Block-serial N-bit subtractor: d = a - b - bi, processed W bits per clock
// through a single shared lookahead slice. Result after N/W RUN cycles.
// Ports:
//   clk        in  : clock, all state on rising edge
//   rst_n      in  : synchronous active-low reset
//   in_valid   in  : operands valid
//   in_ready   out : accepting operands (IDLE only)
//   a, b [N-1:0] in: minuend, subtrahend
//   bi         in  : borrow in
//   out_valid  out : result valid (DONE only)
//   out_ready  in  : consumer accepts result
//   d [N-1:0]  out : difference modulo 2^N
//   bo         out : unsigned borrow out (a < b + bi)
//   ov         out : signed two's-complement overflow
// ---------------------------------------------------------------------------
module seq_block_borrow_lookahead_sub
    import fixed_point_arith_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         bo,
    output logic         ov
);

    localparam int NB = (W >= 1) ? (N / W) : 1;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_BLK = CW'(NB - 1);

    generate
        if (!block_split_ok(N, W)) begin : g_bad_split
            $error("seq_block_borrow_lookahead_sub: N must be a multiple of W and W >= 1");
        end
    endgenerate

    sub_state_e    state_reg,  state_next;
    logic [N-1:0]  a_reg,      a_next;
    logic [N-1:0]  b_reg,      b_next;
    logic [CW-1:0] cnt_reg,    cnt_next;
    logic          borrow_reg, borrow_next;
    logic [N-1:0]  d_reg,      d_next;
    logic          bo_reg,     bo_next;
    logic          ov_reg,     ov_next;

    // Present the current block of each registered operand to the shared slice.
    logic [W-1:0] a_blks [NB];
    logic [W-1:0] b_blks [NB];
    logic [W-1:0] blk_a;
    logic [W-1:0] blk_b;
    logic [W-1:0] blk_d;
    logic         blk_bout;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_blocks
            assign a_blks[gi] = a_reg[gi*W +: W];
            assign b_blks[gi] = b_reg[gi*W +: W];
            // Only the slice addressed by the counter changes during RUN;
            // every other slice keeps its previous value.
            assign d_next[gi*W +: W] =
                (state_reg == ST_RUN && cnt_reg == CW'(gi)) ? blk_d : d_reg[gi*W +: W];
        end
    endgenerate

    assign blk_a = a_blks[cnt_reg];
    assign blk_b = b_blks[cnt_reg];

    borrow_lookahead_sub_block #(
        .W (W)
    ) u_slice (
        .a    (blk_a),
        .b    (blk_b),
        .bin  (borrow_reg),
        .d    (blk_d),
        .bout (blk_bout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            cnt_reg    <= '0;
            borrow_reg <= 1'b0;
            d_reg      <= '0;
            bo_reg     <= 1'b0;
            ov_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            cnt_reg    <= cnt_next;
            borrow_reg <= borrow_next;
            d_reg      <= d_next;
            bo_reg     <= bo_next;
            ov_reg     <= ov_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        cnt_next    = cnt_reg;
        borrow_next = borrow_reg;
        bo_next     = bo_reg;
        ov_next     = ov_reg;
        in_ready    = 1'b0;
        out_valid   = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_next      = a;
                    b_next      = b;
                    borrow_next = bi;
                    cnt_next    = '0;
                    state_next  = ST_RUN;
                end
            end
            ST_RUN: begin
                borrow_next = blk_bout;
                cnt_next    = cnt_reg + 1'b1;
                if (cnt_reg == LAST_BLK) begin
                    bo_next    = blk_bout;
                    // Overflow needs the final sign bit, taken from the
                    // difference as it is being completed this cycle.
                    ov_next    = (a_reg[N-1] != b_reg[N-1]) & (d_next[N-1] != a_reg[N-1]);
                    cnt_next   = '0;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign d  = d_reg;
    assign bo = bo_reg;
    assign ov = ov_reg;

endmodule : seq_block_borrow_lookahead_sub

// File: tb/tb_seq_block_borrow_lookahead_sub.sv
// ---------------------------------------------------------------------------
// tb_seq_block_borrow_lookahead_sub
// Self-checking bench for the block-serial subtractor (N=32, W=8): directed
// corner vectors, back-pressure, mid-operation reset, then random operands
// against an arithmetic reference.
// ---------------------------------------------------------------------------
module tb_seq_block_borrow_lookahead_sub;

    localparam int N       = 32;
    localparam int W       = 8;
    localparam int LAT     = N / W;
    localparam int TIMEOUT = 40;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bi;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] d;
    logic         bo;
    logic         ov;

    int n_checks;
    int n_fail;
    int n_txn;

    // Value d is expected to show before the next result is written.
    logic [N-1:0] prev_d;

    seq_block_borrow_lookahead_sub #(
        .N (N),
        .W (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bo        (bo),
        .ov        (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and let outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain wide arithmetic on the whole operands.
    task automatic ref_sub(input logic [N-1:0] ra, input logic [N-1:0] rb, input logic rbi,
                           output logic [N-1:0] rd, output logic rbo, output logic rov);
        logic [N:0] wide;
        wide = {1'b0, ra} - {1'b0, rb} - {{N{1'b0}}, rbi};
        rd   = wide[N-1:0];
        rbo  = ({1'b0, ra} < ({1'b0, rb} + {{N{1'b0}}, rbi}));
        rov  = (ra[N-1] != rb[N-1]) && (rd[N-1] != ra[N-1]);
    endtask

    // One complete transaction, with `hold` extra DONE cycles of back-pressure.
    // Junk operands are offered with in_valid=1 while busy; they must be ignored.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tbi,
                          input int hold);
        logic [N-1:0] ed;
        logic         ebo;
        logic         eov;
        int           lat;

        ref_sub(ta, tb_v, tbi, ed, ebo, eov);

        check_eq("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        bi       = tbi;
        step();
        // Busy from here on: keep offering different operands.
        a  = $urandom;
        b  = $urandom;
        bi = 1'($urandom_range(0, 1));
        check_eq("in_ready_busy", in_ready, 0);
        check_eq("d_held_run", d, prev_d);

        lat = 0;
        while (!out_valid && lat < TIMEOUT) begin
            step();
            lat++;
        end
        check_eq("latency", lat, LAT);
        check_eq("d", d, ed);
        check_eq("bo", bo, ebo);
        check_eq("ov", ov, eov);

        for (int h = 0; h < hold; h++) begin
            step();
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_in_ready", in_ready, 0);
            check_eq("hold_d", d, ed);
            check_eq("hold_bo", bo, ebo);
            check_eq("hold_ov", ov, eov);
        end

        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq("post_out_valid", out_valid, 0);
        check_eq("post_in_ready", in_ready, 1);
        check_eq("post_d", d, ed);

        prev_d = ed;
        n_txn++;
        $display("txn %0d a=%08h b=%08h bi=%0d -> d=%08h bo=%0d ov=%0d lat=%0d hold=%0d",
                 n_txn, ta, tb_v, tbi, d, bo, ov, lat, hold);
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rbi;

        n_checks  = 0;
        n_fail    = 0;
        n_txn     = 0;
        prev_d    = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bi        = 1'b0;

        step();
        step();
        check_eq("rst_d", d, 0);
        check_eq("rst_bo", bo, 0);
        check_eq("rst_ov", ov, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        step();

        // Directed corners.
        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0);
        run_op(32'h0001_0000, 32'h0000_0000, 1'b1, 0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1);

        // Reset while the counter sits at block 2.
        in_valid = 1'b1;
        a        = 32'h1234_5678;
        b        = 32'h0FED_CBA9;
        bi       = 1'b1;
        step();                 // accepted, block 0 next
        in_valid = 1'b0;
        step();                 // block 0 written
        step();                 // block 1 written, counter at 2
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("midrst_d", d, 0);
        check_eq("midrst_bo", bo, 0);
        check_eq("midrst_ov", ov, 0);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("midrst_no_stale", out_valid, 0);
        end
        prev_d = '0;
        $display("txn reset-at-block-2 d=%08h out_valid=%0d in_ready=%0d", d, out_valid, in_ready);

        // Random operands with biased corner selection.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom; rb = ra; end
                2: begin ra = $urandom; rb = ra + N'($urandom_range(0, 2)); end
                default: begin
                    ra = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
                end
            endcase
            rbi = 1'($urandom_range(0, 1));
            run_op(ra, rb, rbi, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_block_borrow_lookahead_sub
